// File: rtl/trig_burst_gen.sv
// -----------------------------------------------------------------------------
// trig_burst_gen
//
// Multi-channel trigger burst generator for the timing-control fabric.
// A start event (external trigger edge or software strobe) launches a burst:
// wait a programmable delay, then emit a number of pulses of programmable
// width and period on the channels selected by a mask. A pulse count of zero
// selects continuous mode, which runs until aborted.
//
// Optional feature macro: TRIG_BURST_GEN_CNT_EN
//   When defined, adds O_Pulse_Cnt (pulses emitted in the current or last
//   burst, saturating) and O_Miss_Cnt (saturating count of O_Miss events).
//
// Ports:
//   I_clk_100mhz  in   1       system clock, 100 MHz
//   I_Rst_n       in   1       asynchronous active-low reset
//   I_Trig_in     in   1       asynchronous external start (rising edge)
//   I_Sw_Start    in   1       synchronous one-cycle software start
//   I_Abort       in   1       synchronous abort, level
//   I_Delay       in   CNT_W   cycles from start to first pulse
//   I_Width       in   PW_W    pulse high time in cycles (0 treated as 1)
//   I_Period      in   CNT_W   pulse repetition period in cycles
//   I_Num         in   CNT_W   pulses per burst, 0 = continuous
//   I_Ch_Mask     in   NUM_CH  per-channel output enable
//   O_Trig        out  NUM_CH  registered trigger outputs
//   O_Busy        out  1       high from start acceptance until back in IDLE
//   O_Done        out  1       one-cycle pulse at normal burst completion
//   O_Miss        out  1       one-cycle pulse when a start arrives while busy
//   O_Pulse_Cnt   out  CNT_W   (TRIG_BURST_GEN_CNT_EN only)
//   O_Miss_Cnt    out  16      (TRIG_BURST_GEN_CNT_EN only)
//
// Start handshake: a start event is accepted only in IDLE with I_Abort low;
// acceptance is visible as O_Busy rising on the same edge. A start event while
// O_Busy is high (including the DONE cycle) is dropped and answered with a
// one-cycle O_Miss. I_Abort is a level: any non-IDLE state returns to IDLE on
// the next edge and outranks a simultaneous start.
// -----------------------------------------------------------------------------
module trig_burst_gen #(
    parameter int CNT_W       = 32,
    parameter int PW_W        = 16,
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              I_clk_100mhz,
    input  logic              I_Rst_n,
    input  logic              I_Trig_in,
    input  logic              I_Sw_Start,
    input  logic              I_Abort,
    input  logic [CNT_W-1:0]  I_Delay,
    input  logic [PW_W-1:0]   I_Width,
    input  logic [CNT_W-1:0]  I_Period,
    input  logic [CNT_W-1:0]  I_Num,
    input  logic [NUM_CH-1:0] I_Ch_Mask,
    output logic [NUM_CH-1:0] O_Trig,
    output logic              O_Busy,
    output logic              O_Done,
    output logic              O_Miss
`ifdef TRIG_BURST_GEN_CNT_EN
    ,
    output logic [CNT_W-1:0]  O_Pulse_Cnt,
    output logic [15:0]       O_Miss_Cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // -------------------------------------------------------------------------
    // External start: synchroniser chain plus registered rising-edge detect.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   r_ext_start;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge I_clk_100mhz or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_ext_start <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], I_Trig_in};
            r_sync_prev <= w_sync_out;
            r_ext_start <= w_sync_out & ~r_sync_prev;
        end
    end

    logic w_start;
    logic w_accept;

    assign w_start  = r_ext_start | I_Sw_Start;
    assign w_accept = (r_state == S_IDLE) && w_start && !I_Abort;

    // -------------------------------------------------------------------------
    // Configuration sanitisation, applied to the live inputs and captured on
    // acceptance. The width is forced to at least 1, and the period is forced
    // above the width so every period has at least one low cycle.
    // -------------------------------------------------------------------------
    logic [PW_W-1:0]  w_width_eff;
    logic [CNT_W-1:0] w_width_ext;
    logic [CNT_W-1:0] w_period_eff;

    assign w_width_eff  = (I_Width == '0) ? PW_W'(1) : I_Width;
    assign w_width_ext  = CNT_W'(w_width_eff);
    assign w_period_eff = (I_Period <= w_width_ext) ? (w_width_ext + CNT_W'(1)) : I_Period;

    // Latched burst configuration. The HIGH and LOW phases are stored as the
    // terminal value of a zero-based counter, so no phase needs a subtractor
    // in the per-cycle path.
    logic [CNT_W-1:0]  r_delay;
    logic [CNT_W-1:0]  r_high_last;
    logic [CNT_W-1:0]  r_low_last;
    logic [CNT_W-1:0]  r_num;
    logic [NUM_CH-1:0] r_mask;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_pulse_cnt;

    logic              w_last_delay;
    logic              w_last_high;
    logic              w_last_low;
    logic [CNT_W-1:0]  w_pulse_inc;
    logic              w_burst_end;

    // DELAY runs for latched Delay + 1 cycles (counter 0..Delay); together
    // with the output register this puts the first rising edge of O_Trig
    // Delay + 2 cycles after the start cycle.
    assign w_last_delay = (r_cnt == r_delay);
    assign w_last_high  = (r_cnt == r_high_last);
    assign w_last_low   = (r_cnt == r_low_last);

    // Pulse counter saturates at all-ones so continuous mode never wraps.
    assign w_pulse_inc  = (&r_pulse_cnt) ? r_pulse_cnt : (r_pulse_cnt + CNT_W'(1));
    assign w_burst_end  = (r_num != '0) && (w_pulse_inc == r_num);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge I_clk_100mhz or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. Abort outranks every other transition.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state != S_IDLE) && I_Abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (w_last_delay) begin
                        w_state_nxt = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_last_high) begin
                        w_state_nxt = w_burst_end ? S_DONE : S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_last_low) begin
                        w_state_nxt = S_HIGH;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic. Outputs are decoded from the next state and then
    // registered, so they line up with the state register and have no
    // combinational path from the inputs.
    // -------------------------------------------------------------------------
    logic [NUM_CH-1:0] w_trig_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_miss_nxt;

    always_comb begin
        w_trig_nxt = '0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_miss_nxt = 1'b0;
        if (w_state_nxt == S_HIGH) begin
            w_trig_nxt = r_mask;
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
        // Any start seen while not IDLE is a miss, even alongside an abort.
        w_miss_nxt = w_start && (r_state != S_IDLE);
    end

    logic [NUM_CH-1:0] r_trig;
    logic              r_busy;
    logic              r_done;
    logic              r_miss;

    always_ff @(posedge I_clk_100mhz or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_trig <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            r_trig <= w_trig_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_miss <= w_miss_nxt;
        end
    end

    assign O_Trig = r_trig;
    assign O_Busy = r_busy;
    assign O_Done = r_done;
    assign O_Miss = r_miss;

    // -------------------------------------------------------------------------
    // Configuration latch and phase / pulse counters.
    // The pulse counter is only cleared by a new start, so it still reports
    // the previous burst after DONE or abort.
    // -------------------------------------------------------------------------
    always_ff @(posedge I_clk_100mhz or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_delay     <= '0;
            r_high_last <= '0;
            r_low_last  <= '0;
            r_num       <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_pulse_cnt <= '0;
        end else if (w_accept) begin
            r_delay     <= I_Delay;
            r_high_last <= w_width_ext - CNT_W'(1);
            r_low_last  <= w_period_eff - w_width_ext - CNT_W'(1);
            r_num       <= I_Num;
            r_mask      <= I_Ch_Mask;
            r_cnt       <= '0;
            r_pulse_cnt <= '0;
        end else begin
            case (r_state)
                S_DELAY: begin
                    r_cnt <= w_last_delay ? '0 : (r_cnt + CNT_W'(1));
                end
                S_HIGH: begin
                    if (w_last_high) begin
                        r_cnt       <= '0;
                        r_pulse_cnt <= w_pulse_inc;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LOW: begin
                    r_cnt <= w_last_low ? '0 : (r_cnt + CNT_W'(1));
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

`ifdef TRIG_BURST_GEN_CNT_EN
    // Saturating count of miss events; cleared only by reset.
    logic [15:0] r_miss_cnt;

    always_ff @(posedge I_clk_100mhz or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r_miss_cnt <= '0;
        end else if (w_miss_nxt && !(&r_miss_cnt)) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign O_Pulse_Cnt = r_pulse_cnt;
    assign O_Miss_Cnt  = r_miss_cnt;
`endif

endmodule

// File: tb/tb_trig_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_trig_burst_gen
//
// Self-checking bench for trig_burst_gen. A behavioural model computes, from
// the burst schedule (acceptance edge, delay, width, period, count), what
// every output must be after each clock edge and pushes it to exp_q; one
// compare process checks the DUT against it on every falling edge. Directed
// scenarios add hand-computed literal expectations, and a randomized phase
// follows.
// -----------------------------------------------------------------------------
module tb_trig_burst_gen;

    localparam int CNT_W       = 32;
    localparam int PW_W        = 16;
    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;

`ifdef TRIG_BURST_GEN_CNT_EN
    localparam int EXP_W = NUM_CH + 3 + CNT_W + 16;
`else
    localparam int EXP_W = NUM_CH + 3;
`endif

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic              I_Trig_in;
    logic              I_Sw_Start;
    logic              I_Abort;
    logic [CNT_W-1:0]  I_Delay;
    logic [PW_W-1:0]   I_Width;
    logic [CNT_W-1:0]  I_Period;
    logic [CNT_W-1:0]  I_Num;
    logic [NUM_CH-1:0] I_Ch_Mask;
    logic [NUM_CH-1:0] O_Trig;
    logic              O_Busy;
    logic              O_Done;
    logic              O_Miss;
`ifdef TRIG_BURST_GEN_CNT_EN
    logic [CNT_W-1:0]  O_Pulse_Cnt;
    logic [15:0]       O_Miss_Cnt;
`endif

    trig_burst_gen #(
        .CNT_W       (CNT_W),
        .PW_W        (PW_W),
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .I_clk_100mhz (clk),
        .I_Rst_n      (rst_n),
        .I_Trig_in    (I_Trig_in),
        .I_Sw_Start   (I_Sw_Start),
        .I_Abort      (I_Abort),
        .I_Delay      (I_Delay),
        .I_Width      (I_Width),
        .I_Period     (I_Period),
        .I_Num        (I_Num),
        .I_Ch_Mask    (I_Ch_Mask),
        .O_Trig       (O_Trig),
        .O_Busy       (O_Busy),
        .O_Done       (O_Done),
        .O_Miss       (O_Miss)
`ifdef TRIG_BURST_GEN_CNT_EN
        ,
        .O_Pulse_Cnt  (O_Pulse_Cnt),
        .O_Miss_Cnt   (O_Miss_Cnt)
`endif
    );

    // ---------------------------------------------------------------- scoreboard
    int n_cmp = 0;
    int n_bad = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EXP_W-1:0] dut_vec();
`ifdef TRIG_BURST_GEN_CNT_EN
        return {O_Trig, O_Busy, O_Done, O_Miss, O_Pulse_Cnt, O_Miss_Cnt};
`else
        return {O_Trig, O_Busy, O_Done, O_Miss};
`endif
    endfunction

    // ---------------------------------------------------------------- model
    // Burst schedule relative to the acceptance edge a (edge on which a start
    // is taken): pulse j is high after edges a+D+1+j*P .. a+D+j*P+W, O_Done is
    // high after edge a+D+1+(N-1)*P+W and the unit is idle from the next edge.
    longint            m_edge;
    longint            m_a, m_d, m_w, m_p, m_n, m_idle;
    bit                m_act, m_fin, m_trig_prev;
    logic [NUM_CH-1:0] m_mask;
    logic [CNT_W-1:0]  m_pcnt;
    logic [15:0]       m_mcnt;
    longint            m_ext_q[$];

    function automatic bit is_fall_edge(input longint n);
        longint u;
        u = n - m_a - m_d - 1 - m_w;
        if (u < 0) return 1'b0;
        if ((u % m_p) != 0) return 1'b0;
        if (m_fin && (u / m_p) >= m_n) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit                start, ext, miss, e_busy, e_done;
        logic [NUM_CH-1:0] e_trig;
        longint            t, u;
        if (!rst_n) begin
            m_act       = 1'b0;
            m_trig_prev = 1'b0;
            m_pcnt      = '0;
            m_mcnt      = '0;
            m_ext_q.delete();
        end else begin
            m_edge++;
            // An external rising edge first sampled at edge r is accepted by
            // the FSM on edge r + SYNC_STAGES + 1.
            if (I_Trig_in && !m_trig_prev) m_ext_q.push_back(m_edge + SYNC_STAGES + 1);
            m_trig_prev = I_Trig_in;
            ext = 1'b0;
            if (m_ext_q.size() != 0 && m_ext_q[0] == m_edge) begin
                ext = 1'b1;
                void'(m_ext_q.pop_front());
            end
            start = I_Sw_Start | ext;
            miss  = 1'b0;
            if (m_act) begin
                miss = start;
                if (is_fall_edge(m_edge) && m_pcnt != '1) m_pcnt = m_pcnt + 1'b1;
                if (I_Abort || (m_fin && m_edge == m_idle)) m_act = 1'b0;
            end else if (start && !I_Abort) begin
                m_act  = 1'b1;
                m_a    = m_edge;
                m_d    = longint'(I_Delay);
                m_w    = (I_Width == 0) ? 1 : longint'(I_Width);
                m_p    = (longint'(I_Period) <= m_w) ? m_w + 1 : longint'(I_Period);
                m_n    = longint'(I_Num);
                m_fin  = (I_Num != 0);
                m_mask = I_Ch_Mask;
                m_idle = m_a + m_d + 2 + (m_n - 1) * m_p + m_w;
                m_pcnt = '0;
            end
            if (miss && m_mcnt != '1) m_mcnt = m_mcnt + 1'b1;

            e_trig = '0;
            e_busy = m_act;
            e_done = 1'b0;
            if (m_act) begin
                t = m_edge - m_a;
                if (m_fin && m_edge == m_idle - 1) begin
                    e_done = 1'b1;
                end else if (t >= m_d + 1) begin
                    u = t - m_d - 1;
                    if ((u % m_p) < m_w && (!m_fin || (u / m_p) < m_n)) e_trig = m_mask;
                end
            end
`ifdef TRIG_BURST_GEN_CNT_EN
            exp_q.push_back({e_trig, e_busy, e_done, miss, m_pcnt, m_mcnt});
`else
            exp_q.push_back({e_trig, e_busy, e_done, miss});
`endif
        end
    end

    // One compare process: every falling edge, against the model or, while in
    // reset, against the all-zero reset state.
    always @(negedge clk) begin
        logic [EXP_W-1:0] ev;
        if (!rst_n) begin
            check("reset_outputs", dut_vec(), '0);
        end else if (exp_q.size() != 0) begin
            ev = exp_q.pop_front();
            check("cycle_outputs", dut_vec(), ev);
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic set_cfg(input int d, input int w, input int p, input int n, input logic [NUM_CH-1:0] mask);
        I_Delay   = CNT_W'(d);
        I_Width   = PW_W'(w);
        I_Period  = CNT_W'(p);
        I_Num     = CNT_W'(n);
        I_Ch_Mask = mask;
    endtask

    task automatic sw_start();
        @(negedge clk);
        I_Sw_Start = 1'b1;
    endtask

    // Observation window: m counts falling edges after the call; strobes are
    // cleared after the first edge so they last one cycle.
    int ob_rises, ob_high, ob_done, ob_done_m, ob_miss, ob_idle_m;
    bit ob_busy_seen;
    logic [NUM_CH-1:0] ob_union;
    int ob_rise_q[$];

    task automatic observe(input int max_cyc, input bit stop_idle);
        logic [NUM_CH-1:0] prev;
        prev = '0;
        ob_rises = 0; ob_high = 0; ob_done = 0; ob_done_m = -1; ob_miss = 0;
        ob_idle_m = -1; ob_busy_seen = 1'b0; ob_union = '0;
        ob_rise_q.delete();
        for (int m = 1; m <= max_cyc; m++) begin
            @(negedge clk);
            I_Sw_Start = 1'b0;
            I_Abort    = 1'b0;
            if (O_Trig != 0 && prev == 0) begin
                ob_rises++;
                ob_rise_q.push_back(m);
            end
            if (O_Trig != 0) ob_high++;
            ob_union = ob_union | O_Trig;
            if (O_Done) begin
                ob_done++;
                ob_done_m = m;
            end
            if (O_Miss) ob_miss++;
            if (O_Busy) ob_busy_seen = 1'b1;
            prev = O_Trig;
            if (stop_idle && ob_busy_seen && !O_Busy) begin
                ob_idle_m = m;
                return;
            end
        end
    endtask

    task automatic scenario_basic(input string tag);
        set_cfg(10, 24, 100, 3, 4'b0101);
        sw_start();
        observe(400, 1'b1);
        check({tag, "_first_rise"}, ob_rise_q.size() != 0 ? ob_rise_q[0] : -1, 12);
        check({tag, "_rises"}, ob_rises, 3);
        if (ob_rise_q.size() >= 3) begin
            check({tag, "_spacing1"}, ob_rise_q[1] - ob_rise_q[0], 100);
            check({tag, "_spacing2"}, ob_rise_q[2] - ob_rise_q[1], 100);
        end
        check({tag, "_high_cycles"}, ob_high, 72);
        check({tag, "_channels"}, ob_union, 4'b0101);
        check({tag, "_done_count"}, ob_done, 1);
        check({tag, "_done_cycle"}, ob_done_m, 236);
        check({tag, "_idle_cycle"}, ob_idle_m, 237);
`ifdef TRIG_BURST_GEN_CNT_EN
        check({tag, "_pulse_cnt"}, O_Pulse_Cnt, 3);
`endif
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        int k;
        rst_n      = 1'b0;
        I_Trig_in  = 1'b0;
        I_Sw_Start = 1'b0;
        I_Abort    = 1'b0;
        m_edge     = 0;
        set_cfg(0, 1, 2, 1, 4'hF);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Basic three-pulse burst on channels 0 and 2.
        scenario_basic("s1");

        // Degenerate width/period: one cycle high, one low, two pulses.
        set_cfg(0, 0, 0, 2, 4'hF);
        sw_start();
        observe(50, 1'b1);
        check("s2_rises", ob_rises, 2);
        check("s2_first_rise", ob_rise_q.size() != 0 ? ob_rise_q[0] : -1, 2);
        check("s2_high_cycles", ob_high, 2);
        check("s2_done_cycle", ob_done_m, 5);
        check("s2_idle_cycle", ob_idle_m, 6);

        // Continuous mode, then abort in the middle of a pulse.
        set_cfg(3, 5, 20, 0, 4'hF);
        sw_start();
        observe(1005, 1'b0);
        check("s3_rises", ob_rises, 51);
        check("s3_high_cycles", ob_high, 251);
        check("s3_no_done", ob_done, 0);
        k = 0;
        while (O_Trig == 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("s3_found_high", O_Trig != 0, 1);
        @(negedge clk);
        I_Abort = 1'b1;
        @(negedge clk);
        I_Abort = 1'b0;
        check("s3_abort_trig", O_Trig, 0);
        check("s3_abort_busy", O_Busy, 0);
        check("s3_abort_done", O_Done, 0);
        observe(20, 1'b0);
        check("s3_after_abort_done", ob_done, 0);
        check("s3_after_abort_busy", ob_busy_seen, 0);

        // External trigger, a second edge mid-burst, width change mid-burst.
        set_cfg(5, 8, 30, 4, 4'b1010);
        @(negedge clk);
        fork
            begin
                #2 I_Trig_in = 1'b1;
                repeat (50) @(negedge clk);
                I_Trig_in = 1'b0;
                repeat (10) @(negedge clk);
                I_Width = 16'd20;
                repeat (10) @(negedge clk);
                #3 I_Trig_in = 1'b1;
                repeat (5) @(negedge clk);
                I_Trig_in = 1'b0;
            end
            observe(400, 1'b1);
        join
        check("s4_rises", ob_rises, 4);
        check("s4_high_cycles", ob_high, 32);
        check("s4_miss", ob_miss, 1);
        check("s4_done", ob_done, 1);
        check("s4_channels", ob_union, 4'b1010);
        check("s4_idle_reached", ob_idle_m > 0, 1);

        // Start and abort in the same idle cycle: nothing starts.
        set_cfg(2, 3, 10, 2, 4'hF);
        @(negedge clk);
        I_Sw_Start = 1'b1;
        I_Abort    = 1'b1;
        observe(20, 1'b0);
        check("s5_busy_seen", ob_busy_seen, 0);
        check("s5_rises", ob_rises, 0);
        check("s5_miss", ob_miss, 0);

        // Reset during a LOW phase, then a normal burst afterwards.
        set_cfg(2, 4, 16, 3, 4'hF);
        sw_start();
        @(negedge clk);
        I_Sw_Start = 1'b0;
        k = 0;
        while (O_Trig == 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (O_Trig != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("s6_in_low", {O_Busy, O_Trig != 0}, 2'b10);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("s6_rst_trig", O_Trig, 0);
        check("s6_rst_busy", O_Busy, 0);
        check("s6_rst_done", O_Done, 0);
        check("s6_rst_miss", O_Miss, 0);
`ifdef TRIG_BURST_GEN_CNT_EN
        check("s6_rst_pulse_cnt", O_Pulse_Cnt, 0);
        check("s6_rst_miss_cnt", O_Miss_Cnt, 0);
`endif
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        scenario_basic("s7");

        // Randomized phase: configuration changes every cycle, random starts,
        // aborts and asynchronous external edges; the model checks each cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            set_cfg($urandom_range(0, 12), $urandom_range(0, 6), $urandom_range(0, 24),
                    $urandom_range(0, 4), NUM_CH'($urandom_range(0, 15)));
            I_Sw_Start = ($urandom_range(0, 29) == 0);
            I_Abort    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) begin
                #($urandom_range(1, 4)) I_Trig_in = ~I_Trig_in;
            end
        end
        @(negedge clk);
        I_Sw_Start = 1'b0;
        I_Trig_in  = 1'b0;
        I_Abort    = 1'b1;
        @(negedge clk);
        I_Abort = 1'b0;
        repeat (10) @(negedge clk);
        check("final_idle", {O_Busy, O_Trig}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
